shift_ctrl_seq: RTL and testbench
=================================

Name: shift_ctrl_seq

Overview:
- Command sequencer placed directly upstream of the 4-bit universal shift register (74194-style: s1/s0 mode select, parallel d, serial l_in/r_in, clr active-low).
- Accepts one command per valid/ready handshake: load, shift, rotate or clear, with a repeat count.
- Drives the register's mode and serial pins cycle by cycle, then returns the register's q as a result with a one-cycle done pulse.

Parameters:
- WIDTH, 4, data width; must match the shift register width.
- CNT_W, 3, width of the shift-count field; maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command; equals (state==IDLE).
- cmd_op  input  3  opcode, see Behaviour.
- cmd_data  input  WIDTH  parallel load value.
- cmd_cnt  input  CNT_W  number of shift/rotate steps.
- ser_in  input  1  external serial fill bit for SHR/SHL.
- q  input  WIDTH  shift register output, fed back.
- s1  output  1  register mode select bit 1.
- s0  output  1  register mode select bit 0.
- d  output  WIDTH  register parallel input.
- l_in  output  1  register left serial input.
- r_in  output  1  register right serial input.
- sr_clr_n  output  1  register clear, active-low.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  q captured at done; held until the next done.

Behaviour:
- Register convention:
  - s1s0=00 hold; 01 shift right, q <= {r_in, q[W-1:1]}; 10 shift left, q <= {q[W-2:0], l_in}; 11 load d.
  - sr_clr_n=0 with s1s0=00 clears the register.
- Reset (clr=1, asynchronous), outputs:
  - state=IDLE, s1=s0=0, d=0, sr_clr_n=1, done=0, result=0, internal count=0.
  - cmd_ready=1 once the state is IDLE.
- Reset mid-command: the command is aborted, no done pulse is produced, and s1s0 returns to 00 immediately.
- Handshake: a command is accepted on a rising edge with cmd_valid && cmd_ready. The op, data and cnt are latched. cmd_ready stays 0 until the state returns to IDLE.
- Opcodes:
  - 000 NOP
  - 001 LOAD
  - 010 SHR (fill ser_in)
  - 011 SHL (fill ser_in)
  - 100 ROTR
  - 101 ROTL
  - 110 CLEAR
  - 111 LDSHR (load, then shift right cnt steps)
- FSM states: IDLE, LOAD, SHIFT, CLEAR, DONE.
  - IDLE -> LOAD for LOAD/LDSHR.
  - IDLE -> SHIFT for SHR/SHL/ROTR/ROTL when cnt != 0.
  - IDLE -> CLEAR for CLEAR.
  - IDLE -> DONE for NOP, or for a shift/rotate op with cnt == 0.
  - LOAD -> SHIFT for LDSHR with cnt != 0; otherwise LOAD -> DONE.
  - SHIFT lasts exactly cnt cycles (count decrements each cycle), then -> DONE.
  - CLEAR lasts 1 cycle, then -> DONE.
  - DONE lasts 1 cycle, then -> IDLE.
- Outputs per state:
  - s1, s0, d and sr_clr_n are registered and take their state value in the same cycle the state is entered.
  - LOAD: s1s0=11, d=latched data.
  - SHIFT: s1s0=01 for right ops, 10 for left ops.
  - CLEAR: s1s0=00, sr_clr_n=0.
  - All other states: s1s0=00, sr_clr_n=1, d holds its last value.
- Serial inputs (combinational, only active in SHIFT, otherwise 0):
  - SHR and LDSHR: r_in=ser_in.
  - SHL: l_in=ser_in.
  - ROTR: r_in=q[0].
  - ROTL: l_in=q[W-1].
- Latency, with acceptance at edge T:
  - LOAD: done at cycle T+2.
  - n-step shift: done at cycle T+n+1.
  - LDSHR: done at cycle T+n+2.
  - NOP or cnt=0: done at cycle T+1.
- DONE cycle: done=1 and result <= q (the register has already applied the final operation).
- Back-to-back: a new command is accepted no earlier than the edge that leaves DONE, i.e. one IDLE cycle between commands.
- cmd_* changes while cmd_ready=0 are ignored.

Optional Feature:
- Macro SHIFT_CTRL_PARITY_EN.
- Defined: adds output result_par (1 bit), even parity ^q captured together with result at done; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-SHIFT: assert clr during cycle 2 of SHR cnt=3 -> s1s0=00 and cmd_ready=1 asynchronously; no done pulse.
- LOAD: cmd_data=1011 -> s1s0=11 and d=1011 for one cycle; done at T+2 with result=1011.
- LDSHR: cmd_data=1001, cnt=2, ser_in=1 -> s1s0=11 for 1 cycle, then 01 for 2 cycles; result=1110 at T+4.
- ROTL: q=1000, cnt=3 -> l_in follows q[3] each cycle; result=0100 at T+4.
- CLEAR after load of 1111 -> sr_clr_n=0 for exactly 1 cycle; result=0000.
- SHL cnt=0 -> no s1s0 activity; done at T+1 with result=current q; cmd_valid held high gives next acceptance 2 cycles later.

Source files
------------

// File: rtl/shift_ctrl_seq.sv
// Command sequencer driving a 74194-style universal shift register (mode, parallel and serial pins).
// Optional macro SHIFT_CTRL_PARITY_EN adds result_par, the even parity of q captured with result.
module shift_ctrl_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] q,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] d,
  output logic             l_in,
  output logic             r_in,
  output logic             sr_clr_n,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SHIFT_CTRL_PARITY_EN
  ,
  output logic             result_par
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    CLEAR,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_ROTR  = 3'b100,
    OP_ROTL  = 3'b101,
    OP_CLEAR = 3'b110,
    OP_LDSHR = 3'b111
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt_q;
  op_t              op_in;

  assign op_in     = op_t'(cmd_op);
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      s1       <= 1'b0;
      s0       <= 1'b0;
      d        <= '0;
      sr_clr_n <= 1'b1;
      done     <= 1'b0;
      result   <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
      result_par <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= op_in;
            cnt_q <= cmd_cnt;
            case (op_in)
              OP_LOAD, OP_LDSHR: begin
                state <= LOAD;
                s1    <= 1'b1;
                s0    <= 1'b1;
                d     <= cmd_data;
              end
              OP_SHR, OP_ROTR: begin
                if (cmd_cnt != '0) begin
                  state <= SHIFT;
                  s1    <= 1'b0;
                  s0    <= 1'b1;
                end else begin
                  state <= DONE;
                end
              end
              OP_SHL, OP_ROTL: begin
                if (cmd_cnt != '0) begin
                  state <= SHIFT;
                  s1    <= 1'b1;
                  s0    <= 1'b0;
                end else begin
                  state <= DONE;
                end
              end
              OP_CLEAR: begin
                state    <= CLEAR;
                sr_clr_n <= 1'b0;
              end
              default: state <= DONE;
            endcase
          end
        end
        LOAD: begin
          if (op_q == OP_LDSHR && cnt_q != '0) begin
            state <= SHIFT;
            s1    <= 1'b0;
            s0    <= 1'b1;
          end else begin
            state <= DONE;
            s1    <= 1'b0;
            s0    <= 1'b0;
          end
        end
        SHIFT: begin
          // cnt_q holds the steps still to run including the current cycle
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state <= DONE;
            s1    <= 1'b0;
            s0    <= 1'b0;
          end
        end
        CLEAR: begin
          state    <= DONE;
          sr_clr_n <= 1'b1;
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b1;
          result <= q;
`ifdef SHIFT_CTRL_PARITY_EN
          result_par <= ^q;
`endif
        end
        default: begin
          state    <= IDLE;
          s1       <= 1'b0;
          s0       <= 1'b0;
          sr_clr_n <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    l_in = 1'b0;
    r_in = 1'b0;
    if (state == SHIFT) begin
      case (op_q)
        OP_SHR, OP_LDSHR: r_in = ser_in;
        OP_SHL:           l_in = ser_in;
        OP_ROTR:          r_in = q[0];
        OP_ROTL:          l_in = q[WIDTH-1];
        default: begin
          l_in = 1'b0;
          r_in = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_ctrl_seq.sv
// Directed and random checks of shift_ctrl_seq against an arithmetic model of each command.
module tb_shift_ctrl_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic       ser_in;
  logic [3:0] q = 4'b0000;
  logic       s1, s0;
  logic [3:0] d;
  logic       l_in, r_in, sr_clr_n, done;
  logic [3:0] result;
`ifdef SHIFT_CTRL_PARITY_EN
  logic       result_par;
`endif

  int ncmp = 0;
  int nerr = 0;
  logic [3:0] cur = 4'b0000;

  always #5 clk = ~clk;

  shift_ctrl_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .ser_in(ser_in),
    .q(q), .s1(s1), .s0(s0), .d(d), .l_in(l_in), .r_in(r_in),
    .sr_clr_n(sr_clr_n), .done(done), .result(result)
`ifdef SHIFT_CTRL_PARITY_EN
    , .result_par(result_par)
`endif
  );

  // 74194-style register fed by the sequencer
  always_ff @(posedge clk) begin
    if (!sr_clr_n && {s1, s0} == 2'b00) q <= 4'b0000;
    else case ({s1, s0})
      2'b01:   q <= {r_in, q[3:1]};
      2'b10:   q <= {q[2:0], l_in};
      2'b11:   q <= d;
      default: q <= q;
    endcase
  end

  function automatic logic [3:0] shr_f(input logic [3:0] v, input int n, input logic b);
    logic [31:0] t;
    t = {28'h0, v} | (b ? 32'hFFFF_FFF0 : 32'h0);
    return 4'(t >> n);
  endfunction

  function automatic logic [3:0] shl_f(input logic [3:0] v, input int n, input logic b);
    logic [31:0] t;
    t = ({28'h0, v} << n) | (b ? ((32'd1 << n) - 32'd1) : 32'h0);
    return 4'(t);
  endfunction

  function automatic logic [3:0] rot_f(input logic [3:0] v, input int n, input bit left);
    logic [31:0] t;
    int k;
    k = n % 4;
    t = {28'h0, v};
    if (left) return 4'((t << k) | (t >> (4 - k)));
    return 4'((t >> k) | (t << (4 - k)));
  endfunction

  function automatic logic [3:0] model_res(input logic [2:0] op, input logic [3:0] data,
                                          input int n, input logic b, input logic [3:0] v);
    case (op)
      3'd1:    return data;
      3'd2:    return shr_f(v, n, b);
      3'd3:    return shl_f(v, n, b);
      3'd4:    return rot_f(v, n, 1'b0);
      3'd5:    return rot_f(v, n, 1'b1);
      3'd6:    return 4'b0000;
      3'd7:    return shr_f(data, n, b);
      default: return v;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input int n);
    case (op)
      3'd1, 3'd6:             return 2;
      3'd2, 3'd3, 3'd4, 3'd5: return (n == 0) ? 1 : n + 1;
      3'd7:                   return n + 2;
      default:                return 1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench #1 after the accepting edge with cmd_* scrambled (must be ignored)
  task automatic accept(input logic [2:0] op, input logic [3:0] data, input logic [2:0] cnt,
                        input logic b);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt; ser_in = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_data = 4'($urandom); cmd_cnt = 3'($urandom);
    check("ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int elapsed, input logic [3:0] exp_r,
                           input int lat);
    int k;
    k = elapsed;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat));
    check({tag, "_result"}, 32'(result), 32'(exp_r));
`ifdef SHIFT_CTRL_PARITY_EN
    check({tag, "_parity"}, 32'(result_par), 32'(^exp_r));
`endif
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(done), 32'd0);
    cur = exp_r;
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input logic b);
    logic [3:0] exp_r;
    exp_r = model_res(op, data, int'(cnt), b, cur);
    accept(op, data, cnt, b);
    wait_done(tag, 0, exp_r, model_lat(op, int'(cnt)));
  endtask

  initial begin
    logic [3:0] v;
    int ndone;
    logic [2:0] rop;
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_cnt = '0; ser_in = 1'b0;
    #1;
    check("rst_s1s0", 32'({s1, s0}), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_clr_n", 32'(sr_clr_n), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b0;

    // LOAD 1011: one cycle of parallel load, d then holds
    accept(3'd1, 4'b1011, 3'd0, 1'b0);
    check("load_s1s0", 32'({s1, s0}), 32'd3);
    check("load_d", 32'(d), 32'hb);
    @(posedge clk); #1;
    check("load_s1s0_after", 32'({s1, s0}), 32'd0);
    check("load_d_hold", 32'(d), 32'hb);
    wait_done("load", 1, 4'b1011, 2);

    // LDSHR 1001, cnt 2, fill 1
    accept(3'd7, 4'b1001, 3'd2, 1'b1);
    check("ldshr_s1s0_0", 32'({s1, s0}), 32'd3);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("ldshr_s1s0_sh", 32'({s1, s0}), 32'd1);
      check("ldshr_r_in", 32'(r_in), 32'd1);
    end
    @(posedge clk); #1;
    check("ldshr_s1s0_end", 32'({s1, s0}), 32'd0);
    wait_done("ldshr", 3, 4'b1110, 4);

    // ROTL of 1000 by 3: l_in tracks the MSB each step
    run_cmd("pre_rotl", 3'd1, 4'b1000, 3'd0, 1'b0);
    v = 4'b1000;
    accept(3'd5, 4'b0000, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("rotl_s1s0", 32'({s1, s0}), 32'd2);
      check("rotl_l_in", 32'(l_in), 32'(v[3]));
      check("rotl_r_in", 32'(r_in), 32'd0);
      v = rot_f(v, 1, 1'b1);
      @(posedge clk); #1;
    end
    wait_done("rotl", 3, 4'b0100, 4);

    // CLEAR after loading 1111
    run_cmd("pre_clear", 3'd1, 4'b1111, 3'd0, 1'b0);
    accept(3'd6, 4'b0000, 3'd0, 1'b0);
    check("clear_clr_n", 32'(sr_clr_n), 32'd0);
    check("clear_s1s0", 32'({s1, s0}), 32'd0);
    @(posedge clk); #1;
    check("clear_clr_n_after", 32'(sr_clr_n), 32'd1);
    wait_done("clear", 1, 4'b0000, 2);

    // SHL cnt=0 with cmd_valid held: done next cycle, re-accepted two cycles after
    run_cmd("pre_shl0", 3'd1, 4'b0110, 3'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_data = 4'b0000; cmd_cnt = 3'd0; ser_in = 1'b1;
    @(posedge clk); #1;
    check("shl0_busy", 32'(cmd_ready), 32'd0);
    check("shl0_s1s0", 32'({s1, s0}), 32'd0);
    @(posedge clk); #1;
    check("shl0_done", 32'(done), 32'd1);
    check("shl0_result", 32'(result), 32'(cur));
    check("shl0_idle", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("shl0_reaccept", 32'(cmd_ready), 32'd0);
    check("shl0_s1s0_2", 32'({s1, s0}), 32'd0);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("shl0_done2", 32'(done), 32'd1);
    check("shl0_result2", 32'(result), 32'(cur));
    @(posedge clk); #1;

    // Reset in the second cycle of SHR cnt=3: exactly one step applied, no done
    run_cmd("pre_rst", 3'd1, 4'b0101, 3'd0, 1'b0);
    accept(3'd2, 4'b0000, 3'd3, 1'b1);
    @(posedge clk); #1;
    check("rstmid_s1s0", 32'({s1, s0}), 32'd1);
    #2 clr = 1'b1;
    #1;
    check("rstmid_s1s0_async", 32'({s1, s0}), 32'd0);
    check("rstmid_ready_async", 32'(cmd_ready), 32'd1);
    @(negedge clk) clr = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("rstmid_no_done", 32'(ndone), 32'd0);
    cur = shr_f(4'b0101, 2, 1'b1) == 4'b0000 ? 4'b0000 : shr_f(4'b0101, 1, 1'b1);
    run_cmd("post_rst_nop", 3'd0, 4'b0000, 3'd0, 1'b0);

    // Random commands
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_cmd("rand", rop, 4'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
